// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: {CO,S} = A + B + CI, one 4-bit slice per cycle, LS nibble first.
// Latency: WIDTH/4 edges from the START-capture edge to the S/CO update; DONE pulses the following cycle.
// Backpressure: START is ignored while BUSY; a START during the DONE cycle is accepted (zero-gap back-to-back).
//
// Ports:
//   CK     - clock, rising edge
//   CDN    - asynchronous active-low reset
//   START  - begin an addition (sampled only when idle)
//   A, B   - WIDTH-bit operands, captured at START
//   CI     - carry-in, captured at START
//   S, CO  - registered sum / carry-out, held until the next completion
//   BUSY   - high while an addition is in progress
//   DONE   - one-cycle pulse after S/CO update
//   OVF    - signed overflow of the completed addition (only with NIBBLE_SERIAL_ADDER_OVF_EN)
//
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN adds the OVF output.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             CK,
    input  logic             CDN,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             BUSY,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             DONE,
    output logic             OVF
`else
    output logic             DONE
`endif
);

    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;     // operand A, shifted right one nibble per RUN cycle
    logic [WIDTH-1:0] r_b;     // operand B, shifted right one nibble per RUN cycle
    logic [WIDTH-1:0] r_res;   // result, filled from the top so nibble 0 lands at the bottom
    logic             r_c;     // carry between slices
    logic [CW-1:0]    r_cnt;   // index of the nibble being processed

    // The current nibble always sits in the low 4 bits of the shifting operand registers.
    logic [4:0] w_sum;
    logic       w_last;
    assign w_sum  = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_c};
    assign w_last = (r_cnt == CW'(N - 1));

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
    logic w_c_into_msb;
    assign w_c_into_msb = w_sum[3] ^ r_a[3] ^ r_b[3];
`endif

    assign BUSY = (r_state == RUN);

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            S       <= '0;
            CO      <= 1'b0;
            DONE    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            OVF     <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= CI;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= {4'b0, r_a[WIDTH-1:4]};
                    r_b   <= {4'b0, r_b[WIDTH-1:4]};
                    r_res <= {w_sum[3:0], r_res[WIDTH-1:4]};
                    r_c   <= w_sum[4];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Final slice goes straight to S so no partial value is ever visible.
                        S       <= {w_sum[3:0], r_res[WIDTH-1:4]};
                        CO      <= w_sum[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        OVF     <= w_c_into_msb ^ w_sum[4];
`endif
                        DONE    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
